fft_butterfly_pipe_rtl: RTL and testbench
=========================================

FFT_BUTTERFLY_PIPE_RTL -- requirements
Module: fft_butterfly_pipe_rtl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed two's-complement width of every data component.
REQ-002 SHALL have parameter FRAC, default 8, range 1..WIDTH-2: fractional bits of the twiddle factor; 1.0 = 2^FRAC.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  input beat present.
REQ-006 in_ready  out  1  block accepts the beat this cycle.
REQ-007 first_re, first_im  in  WIDTH each  upper butterfly operand.
REQ-008 second_re, second_im  in  WIDTH each  lower butterfly operand.
REQ-009 tw_re, tw_im  in  WIDTH each  twiddle factor, Q(WIDTH-FRAC).FRAC.
REQ-010 bypass  in  1  twiddle treated as exactly 1.0 (first FFT stage).
REQ-011 scale  in  1  outputs halved (per-stage block scaling).
REQ-012 out_valid  out  1  output beat present.
REQ-013 out_ready  in  1  downstream accepts the output beat.
REQ-014 first_out_re, first_out_im, second_out_re, second_out_im  out  WIDTH each  butterfly results.
REQ-015 sat_flag  out  1  sticky flag: some output component was saturated.
REQ-016 sat_clear  in  1  synchronous clear of sat_flag.

Function
REQ-017 Pipeline SHALL be 4 stages; accepted beat appears at out_valid exactly 4 enabled cycles after acceptance.
REQ-018 Stage enable en = !out_valid | out_ready; in_ready SHALL equal en combinationally; beat accepted when in_valid & in_ready.
REQ-019 When en=0 all stage data and valid bits SHALL hold; outputs stable while out_valid & !out_ready.
REQ-020 When en=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 1; bubbles SHALL NOT assert out_valid or affect sat_flag.
REQ-021 bypass and scale SHALL be captured with the beat and travel with it; changes between beats SHALL not affect beats in flight.
REQ-022 Stage 1: register operands, twiddle, bypass, scale, valid.
REQ-023 Stage 2: register the four full-precision 2*WIDTH-bit signed products re*re, im*im, re*im, im*re of second and twiddle.
REQ-024 Stage 3: p_re = (sr*tr - si*ti + 2^(FRAC-1)) >>> FRAC, p_im = (sr*ti + si*tr + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round-half-up, no intermediate truncation; if bypass, p = second sign-extended unchanged; first delayed to align.
REQ-025 Stage 4: s = first + p, d = first - p at full width; if scale, s and d = (v + 1) >>> 1; each component saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; result registered to outputs.
REQ-026 sat_flag SHALL set in the cycle a valid beat with any saturated component is registered to the outputs; sat_clear has priority over a simultaneous set only when no saturating beat is registered that cycle (set wins).
REQ-027 No other state; throughput one beat per cycle when out_ready=1.

Reset
REQ-028 While reset=1: all stage valid bits, out_valid, sat_flag SHALL be 0; all data outputs 0; takes effect without a clock edge.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no out_valid until a beat accepted after reset release completes 4 enabled cycles.
REQ-030 in_ready SHALL be 1 in the first cycle after reset release.

Verification (WIDTH=16, FRAC=8)
REQ-031 first=(256,0), second=(512,256), tw=(0,256), bypass=0, scale=0 -> 4 cycles later first_out=(0,512), second_out=(512,-512), sat_flag=0.
REQ-032 first=(32767,0), second=(32767,0), bypass=1 -> first_out=(32767,0), second_out=(0,0), sat_flag=1; sat_clear pulse -> sat_flag=0.
REQ-033 first=(3,-3), second=(0,0), bypass=1, scale=1 -> first_out=(2,-1), second_out=(2,-1).
REQ-034 Stream 8 beats, out_ready low for 3 cycles after 4th output -> in_ready=0, outputs held, all 8 beats delivered in order, none lost or duplicated.
REQ-035 Assert reset asynchronously with 3 beats in flight -> out_valid=0 and outputs 0 immediately; no stale beat appears after release.

Source files
------------

// File: rtl/fft_butterfly_pipe_rtl.sv
// Radix-2 DIT butterfly: first +/- second*twiddle, four register stages with
// valid/ready flow control, optional per-stage halving and saturation.
module fft_butterfly_pipe_rtl #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] first_re,
    input  logic signed [WIDTH-1:0] first_im,
    input  logic signed [WIDTH-1:0] second_re,
    input  logic signed [WIDTH-1:0] second_im,
    input  logic signed [WIDTH-1:0] tw_re,
    input  logic signed [WIDTH-1:0] tw_im,
    input  logic                    bypass,
    input  logic                    scale,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] first_out_re,
    output logic signed [WIDTH-1:0] first_out_im,
    output logic signed [WIDTH-1:0] second_out_re,
    output logic signed [WIDTH-1:0] second_out_im,
    output logic                    sat_flag,
    input  logic                    sat_clear
);

    localparam int PW = 2 * WIDTH;
    // Three guard bits cover the product difference, the rounding add and first +/- p.
    localparam int AW = 2 * WIDTH + 3;

    localparam logic signed [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [AW-1:0] RND  = ONE <<< (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] v);
        round_shift = (v + RND) >>> FRAC;
    endfunction

    function automatic logic signed [AW-1:0] half_round(input logic signed [AW-1:0] v,
                                                        input logic scl);
        half_round = scl ? ((v + ONE) >>> 1) : v;
    endfunction

    function automatic logic is_sat(input logic signed [AW-1:0] v);
        is_sat = (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [AW-1:0] v);
        if (v > MAXV)      saturate = MAXV[WIDTH-1:0];
        else if (v < MINV) saturate = MINV[WIDTH-1:0];
        else               saturate = v[WIDTH-1:0];
    endfunction

    logic en;

    // Control state
    logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic out_valid_q, out_valid_d, sat_flag_q, sat_flag_d;

    // Stage 1 data
    logic signed [WIDTH-1:0] fr_p1_q, fr_p1_d, fi_p1_q, fi_p1_d;
    logic signed [WIDTH-1:0] sr_p1_q, sr_p1_d, si_p1_q, si_p1_d;
    logic signed [WIDTH-1:0] tr_p1_q, tr_p1_d, ti_p1_q, ti_p1_d;
    logic                    byp_p1_q, byp_p1_d, scl_p1_q, scl_p1_d;

    // Stage 2 data
    logic signed [WIDTH-1:0] fr_p2_q, fr_p2_d, fi_p2_q, fi_p2_d;
    logic signed [WIDTH-1:0] sr_p2_q, sr_p2_d, si_p2_q, si_p2_d;
    logic signed [PW-1:0]    rr_p2_q, rr_p2_d, ii_p2_q, ii_p2_d;
    logic signed [PW-1:0]    ri_p2_q, ri_p2_d, ir_p2_q, ir_p2_d;
    logic                    byp_p2_q, byp_p2_d, scl_p2_q, scl_p2_d;

    // Stage 3 data
    logic signed [WIDTH-1:0] fr_p3_q, fr_p3_d, fi_p3_q, fi_p3_d;
    logic signed [AW-1:0]    pre_p3_q, pre_p3_d, pim_p3_q, pim_p3_d;
    logic                    scl_p3_q, scl_p3_d;

    // Stage 4 (output) data
    logic signed [WIDTH-1:0] fo_re_q, fo_re_d, fo_im_q, fo_im_d;
    logic signed [WIDTH-1:0] so_re_q, so_re_d, so_im_q, so_im_d;

    logic signed [AW-1:0] acc_re, acc_im;
    logic signed [AW-1:0] s_re, s_im, d_re, d_im;
    logic                 sat_any, sat_set;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        vld_p1_d = vld_p1_q;
        fr_p1_d  = fr_p1_q;
        fi_p1_d  = fi_p1_q;
        sr_p1_d  = sr_p1_q;
        si_p1_d  = si_p1_q;
        tr_p1_d  = tr_p1_q;
        ti_p1_d  = ti_p1_q;
        byp_p1_d = byp_p1_q;
        scl_p1_d = scl_p1_q;
        if (en) begin
            vld_p1_d = in_valid;
            fr_p1_d  = first_re;
            fi_p1_d  = first_im;
            sr_p1_d  = second_re;
            si_p1_d  = second_im;
            tr_p1_d  = tw_re;
            ti_p1_d  = tw_im;
            byp_p1_d = bypass;
            scl_p1_d = scale;
        end
    end

    // Stage 1 -> 2: full-precision complex products
    always_comb begin
        vld_p2_d = vld_p2_q;
        fr_p2_d  = fr_p2_q;
        fi_p2_d  = fi_p2_q;
        sr_p2_d  = sr_p2_q;
        si_p2_d  = si_p2_q;
        rr_p2_d  = rr_p2_q;
        ii_p2_d  = ii_p2_q;
        ri_p2_d  = ri_p2_q;
        ir_p2_d  = ir_p2_q;
        byp_p2_d = byp_p2_q;
        scl_p2_d = scl_p2_q;
        if (en) begin
            vld_p2_d = vld_p1_q;
            fr_p2_d  = fr_p1_q;
            fi_p2_d  = fi_p1_q;
            sr_p2_d  = sr_p1_q;
            si_p2_d  = si_p1_q;
            rr_p2_d  = sr_p1_q * tr_p1_q;
            ii_p2_d  = si_p1_q * ti_p1_q;
            ri_p2_d  = sr_p1_q * ti_p1_q;
            ir_p2_d  = si_p1_q * tr_p1_q;
            byp_p2_d = byp_p1_q;
            scl_p2_d = scl_p1_q;
        end
    end

    // Stage 2 -> 3: combine products and round back to the data scale
    always_comb begin
        acc_re   = round_shift(AW'(rr_p2_q) - AW'(ii_p2_q));
        acc_im   = round_shift(AW'(ri_p2_q) + AW'(ir_p2_q));
        vld_p3_d = vld_p3_q;
        fr_p3_d  = fr_p3_q;
        fi_p3_d  = fi_p3_q;
        pre_p3_d = pre_p3_q;
        pim_p3_d = pim_p3_q;
        scl_p3_d = scl_p3_q;
        if (en) begin
            vld_p3_d = vld_p2_q;
            fr_p3_d  = fr_p2_q;
            fi_p3_d  = fi_p2_q;
            pre_p3_d = byp_p2_q ? AW'(sr_p2_q) : acc_re;
            pim_p3_d = byp_p2_q ? AW'(si_p2_q) : acc_im;
            scl_p3_d = scl_p2_q;
        end
    end

    // Stage 3 -> 4: sum/difference, optional halving, saturation
    always_comb begin
        s_re    = half_round(AW'(fr_p3_q) + pre_p3_q, scl_p3_q);
        s_im    = half_round(AW'(fi_p3_q) + pim_p3_q, scl_p3_q);
        d_re    = half_round(AW'(fr_p3_q) - pre_p3_q, scl_p3_q);
        d_im    = half_round(AW'(fi_p3_q) - pim_p3_q, scl_p3_q);
        sat_any = is_sat(s_re) || is_sat(s_im) || is_sat(d_re) || is_sat(d_im);
        sat_set = en && vld_p3_q && sat_any;

        out_valid_d = out_valid_q;
        fo_re_d     = fo_re_q;
        fo_im_d     = fo_im_q;
        so_re_d     = so_re_q;
        so_im_d     = so_im_q;
        if (en) begin
            out_valid_d = vld_p3_q;
            fo_re_d     = saturate(s_re);
            fo_im_d     = saturate(s_im);
            so_re_d     = saturate(d_re);
            so_im_d     = saturate(d_im);
        end

        // A saturating beat landing this cycle overrides a simultaneous clear.
        if (sat_set)        sat_flag_d = 1'b1;
        else if (sat_clear) sat_flag_d = 1'b0;
        else                sat_flag_d = sat_flag_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            fo_re_q     <= '0;
            fo_im_q     <= '0;
            so_re_q     <= '0;
            so_im_q     <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            out_valid_q <= out_valid_d;
            sat_flag_q  <= sat_flag_d;
            fo_re_q     <= fo_re_d;
            fo_im_q     <= fo_im_d;
            so_re_q     <= so_re_d;
            so_im_q     <= so_im_d;
        end
    end

    always_ff @(posedge clk) begin
        fr_p1_q  <= fr_p1_d;
        fi_p1_q  <= fi_p1_d;
        sr_p1_q  <= sr_p1_d;
        si_p1_q  <= si_p1_d;
        tr_p1_q  <= tr_p1_d;
        ti_p1_q  <= ti_p1_d;
        byp_p1_q <= byp_p1_d;
        scl_p1_q <= scl_p1_d;
        fr_p2_q  <= fr_p2_d;
        fi_p2_q  <= fi_p2_d;
        sr_p2_q  <= sr_p2_d;
        si_p2_q  <= si_p2_d;
        rr_p2_q  <= rr_p2_d;
        ii_p2_q  <= ii_p2_d;
        ri_p2_q  <= ri_p2_d;
        ir_p2_q  <= ir_p2_d;
        byp_p2_q <= byp_p2_d;
        scl_p2_q <= scl_p2_d;
        fr_p3_q  <= fr_p3_d;
        fi_p3_q  <= fi_p3_d;
        pre_p3_q <= pre_p3_d;
        pim_p3_q <= pim_p3_d;
        scl_p3_q <= scl_p3_d;
    end

    assign out_valid     = out_valid_q;
    assign sat_flag      = sat_flag_q;
    assign first_out_re  = fo_re_q;
    assign first_out_im  = fo_im_q;
    assign second_out_re = so_re_q;
    assign second_out_im = so_im_q;

endmodule

// File: tb/tb_fft_butterfly_pipe_rtl.sv
// Bench for fft_butterfly_pipe_rtl: directed steps plus a queue scoreboard
// fed from an arithmetic reference model of the butterfly.
module tb_fft_butterfly_pipe_rtl;

    localparam int W = 16;
    localparam int F = 8;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, bypass, scale, out_valid, out_ready, sat_flag, sat_clear;
    logic signed [W-1:0] first_re, first_im, second_re, second_im, tw_re, tw_im;
    logic signed [W-1:0] first_out_re, first_out_im, second_out_re, second_out_im;

    typedef struct {
        logic signed [W-1:0] fre;
        logic signed [W-1:0] fim;
        logic signed [W-1:0] sre;
        logic signed [W-1:0] sim;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    fft_butterfly_pipe_rtl #(.WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .first_re(first_re), .first_im(first_im), .second_re(second_re), .second_im(second_im),
        .tw_re(tw_re), .tw_im(tw_im), .bypass(bypass), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .first_out_re(first_out_re), .first_out_im(first_out_im),
        .second_out_re(second_out_re), .second_out_im(second_out_im),
        .sat_flag(sat_flag), .sat_clear(sat_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [W-1:0] clamp(input longint v);
        if (v > 32767)       clamp = 16'sh7fff;
        else if (v < -32768) clamp = 16'sh8000;
        else                 clamp = 16'(v);
    endfunction

    function automatic longint halve(input longint v, input logic scl);
        halve = scl ? ((v + 1) >>> 1) : v;
    endfunction

    function automatic exp_t model(input longint fr, fi, sr, si, tr, ti, input logic byp, scl);
        longint pr, pi;
        exp_t e;
        if (byp) begin
            pr = sr;
            pi = si;
        end else begin
            pr = (sr * tr - si * ti + (64'sd1 <<< (F - 1))) >>> F;
            pi = (sr * ti + si * tr + (64'sd1 <<< (F - 1))) >>> F;
        end
        e.fre = clamp(halve(fr + pr, scl));
        e.fim = clamp(halve(fi + pi, scl));
        e.sre = clamp(halve(fr - pr, scl));
        e.sim = clamp(halve(fi - pi, scl));
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready)
                sb.push_back(model(first_re, first_im, second_re, second_im, tw_re, tw_im, bypass, scale));
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out observed=out_valid expected=no_beat_pending");
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_first_re", first_out_re, e.fre);
                    chk("sb_first_im", first_out_im, e.fim);
                    chk("sb_second_re", second_out_re, e.sre);
                    chk("sb_second_im", second_out_im, e.sim);
                end
                n_out++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic signed [W-1:0] a, b, c, d, e, f, input logic byp, scl);
        bit ok;
        ok        = 1'b0;
        first_re  = a;
        first_im  = b;
        second_re = c;
        second_im = d;
        tw_re     = e;
        tw_im     = f;
        bypass    = byp;
        scale     = scl;
        in_valid  = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        int  base;
        bit  got;
        logic signed [W-1:0] va, vb, vc, vd, ve, vf;
        logic signed [W-1:0] twr[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
        logic signed [W-1:0] twi[8] = '{0, -181, -256, -181, 0, 181, 256, 181};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
        bypass = 1'b0; scale = 1'b0;
        first_re = '0; first_im = '0; second_re = '0; second_im = '0; tw_re = '0; tw_im = '0;

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_first_out_re", first_out_re, 0);
        chk("rst_second_out_im", second_out_im, 0);
        wait_cycles(2);
        reset = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);

        // Complex multiply by j, with exact latency
        send(256, 0, 512, 256, 0, 256, 0, 0);
        chk("lat_c1", out_valid, 0);
        wait_cycles(1);
        chk("lat_c2", out_valid, 0);
        wait_cycles(1);
        chk("lat_c3", out_valid, 0);
        wait_cycles(1);
        chk("lat_c4", out_valid, 1);
        chk("j_first_re", first_out_re, 0);
        chk("j_first_im", first_out_im, 512);
        chk("j_second_re", second_out_re, 512);
        chk("j_second_im", second_out_im, -512);
        chk("j_sat_flag", sat_flag, 0);
        drain("j_drain");

        // Saturation, sticky flag and clear
        send(32767, 0, 32767, 0, 0, 0, 1, 0);
        wait_cycles(3);
        chk("sat_first_re", first_out_re, 32767);
        chk("sat_first_im", first_out_im, 0);
        chk("sat_second_re", second_out_re, 0);
        chk("sat_flag_set", sat_flag, 1);
        wait_cycles(2);
        chk("sat_flag_sticky", sat_flag, 1);
        sat_clear = 1'b1;
        wait_cycles(1);
        sat_clear = 1'b0;
        chk("sat_flag_cleared", sat_flag, 0);

        // Set wins over a simultaneous clear
        send(32767, 0, 32767, 0, 0, 0, 1, 0);
        wait_cycles(2);
        sat_clear = 1'b1;
        wait_cycles(1);
        sat_clear = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
        sat_clear = 1'b1;
        wait_cycles(1);
        sat_clear = 1'b0;
        chk("sat_clear_again", sat_flag, 0);
        drain("sat_drain");

        // Scaling with round-half-up
        send(3, -3, 0, 0, 0, 0, 1, 1);
        wait_cycles(3);
        chk("scl_first_re", first_out_re, 2);
        chk("scl_first_im", first_out_im, -1);
        chk("scl_second_re", second_out_re, 2);
        chk("scl_second_im", second_out_im, -1);
        chk("scl_sat_flag", sat_flag, 0);
        drain("scl_drain");

        // Streaming with downstream stall after the 4th output
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    va = 16'(i * 4001 - 15000);
                    vb = 16'(7000 - i * 2500);
                    vc = 16'(i * 3000 - 12000);
                    vd = 16'(5000 - i * 1700);
                    ve = twr[i];
                    vf = twi[i];
                    send(va, vb, vc, vd, ve, vf, (i == 5), i[0]);
                end
            end
            begin
                got = 1'b0;
                for (int n = 0; n < 100; n++) begin
                    @(posedge clk); #1;
                    if (n_out >= base + 4) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("stall_reach4", got, 1);
                chk("stall_count4", n_out - base, 4);
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        chk("stall_hold_first_re", first_out_re, sb[0].fre);
                        chk("stall_hold_second_im", second_out_im, sb[0].sim);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("stream_drain");
        chk("stream_count", n_out - base, 8);

        // Asynchronous reset with beats in flight
        send(100, 1, 2, 3, 256, 0, 0, 0);
        send(200, 4, 5, 6, 256, 0, 0, 0);
        send(300, 7, 8, 9, 256, 0, 0, 0);
        wait_cycles(1);
        chk("inflight_out_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_first_out_re", first_out_re, 0);
        chk("arst_first_out_im", first_out_im, 0);
        chk("arst_second_out_re", second_out_re, 0);
        wait_cycles(2);
        reset = 1'b0;
        chk("arst_in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            wait_cycles(1);
            chk("arst_no_stale", out_valid, 0);
        end

        // Operation resumes after reset
        send(256, 0, 512, 256, 0, 256, 0, 0);
        wait_cycles(3);
        chk("resume_out_valid", out_valid, 1);
        chk("resume_first_im", first_out_im, 512);
        chk("resume_second_re", second_out_re, 512);
        drain("resume_drain");
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
